multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/rv_ctrl_pkg.sv | 62 ++++++
 rtl/multicycle_ctrl_if.sv | 9 +
 rtl/mem_wait_timer.sv | 30 +++
 rtl/multicycle_ctrl.sv | 148 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states, opcodes,
// ALU/immediate select codes and the bundled control-word type.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_FAULT    = 4'd9
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_FOUR = 2'b01,
        SRCB_IMM  = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10
    } imm_sel_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       pc_src;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        imm_sel_t   imm_sel;
        logic       fault;
    } ctrl_t;

    // States that hold a memory request open and therefore run the wait timer.
    function automatic logic is_wait_state(input state_t s);
        return s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/ready handshake between the controller (master) and memory (slave).
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles and flags the cycle on which the wait limit is hit.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    // The stall that would be the MEM_TIMEOUT-th one trips the limit in that same cycle.
    assign expired = (MEM_TIMEOUT != 0) && inc && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 main control FSM: Moore control word per state, memory
// wait timeout, and a sticky FAULT state left only through reset.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic               zero,
    multicycle_ctrl_if.master  mem,
    output logic               pc_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic               pc_src,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         imm_sel,
    output logic               fault,
    output logic [3:0]         state
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t           cur_state;
    state_t           nxt_state;
    state_t           dec_state;
    ctrl_t            ctrl;
    logic             wait_inc;
    logic             timed_out;
    logic [CNT_W-1:0] wait_count;

    always_ff @(posedge clk) begin
        if (rst) cur_state <= S_FETCH;
        else     cur_state <= nxt_state;
    end

    // Any state change restarts the counter, which covers entry into each wait state.
    assign wait_inc = is_wait_state(cur_state) && !mem.mem_ready;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (nxt_state != cur_state),
        .inc     (wait_inc),
        .count   (wait_count),
        .expired (timed_out)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_FETCH:    if (mem.mem_ready) nxt_state = S_DECODE;
                        else if (timed_out) nxt_state = S_FAULT;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt_state = S_MEM_ADDR;
                    OP_RTYPE, OP_ITYPE: nxt_state = S_EXEC;
                    OP_BRANCH:         nxt_state = S_BRANCH;
                    default:           nxt_state = S_FAULT;
                endcase
            end
            S_MEM_ADDR: nxt_state = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem.mem_ready) nxt_state = S_MEM_WB;
                        else if (timed_out) nxt_state = S_FAULT;
            S_MEM_WB:   nxt_state = S_FETCH;
            S_MEM_WR:   if (mem.mem_ready) nxt_state = S_FETCH;
                        else if (timed_out) nxt_state = S_FAULT;
            S_EXEC:     nxt_state = S_ALU_WB;
            S_ALU_WB:   nxt_state = S_FETCH;
            S_BRANCH:   nxt_state = S_FETCH;
            S_FAULT:    nxt_state = S_FAULT;
            default:    nxt_state = S_FAULT;
        endcase
    end

    // While rst is high the outputs already show the FETCH decode.
    assign dec_state = rst ? S_FETCH : cur_state;

    always_comb begin
        ctrl = '0;
        case (dec_state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem.mem_ready;
                ctrl.pc_write  = mem.mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_sel   = IMM_B;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_RD: ctrl.mem_req = 1'b1;
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
                if (opcode != OP_RTYPE) begin
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.imm_sel   = IMM_I;
                end
            end
            S_ALU_WB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = 1'b1;
                ctrl.pc_write  = zero;
            end
            S_FAULT: ctrl.fault = 1'b1;
            default: ctrl.fault = 1'b1;
        endcase
    end

    assign mem.mem_req = ctrl.mem_req;
    assign mem.mem_we  = ctrl.mem_we;
    assign pc_write    = ctrl.pc_write;
    assign ir_write    = ctrl.ir_write;
    assign reg_write   = ctrl.reg_write;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign alu_src_a   = ctrl.alu_src_a;
    assign pc_src      = ctrl.pc_src;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_op      = ctrl.alu_op;
    assign imm_sel     = ctrl.imm_sel;
    assign fault       = ctrl.fault;
    assign state       = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction flows, memory stalls,
// timeout into FAULT, and reset recovery.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       pc_write, ir_write, reg_write, mem_to_reg, alu_src_a, pc_src, fault;
    logic [1:0] alu_src_b, alu_op, imm_sel;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl_if mem_bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem        (mem_bus),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .pc_src     (pc_src),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_sel    (imm_sel),
        .fault      (fault),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        opcode = 7'b0000011;
        zero = 1'b0;
        mem_bus.mem_ready = 1'b0;
        tick();
        tick();

        // Reset: FETCH decode, write strobes follow mem_ready.
        check("rst_state", state, 4'd0);
        check("rst_mem_req", mem_bus.mem_req, 1'b1);
        check("rst_srcb", alu_src_b, 2'b01);
        check("rst_irw_lo", ir_write, 1'b0);
        check("rst_fault", fault, 1'b0);
        mem_bus.mem_ready = 1'b1;
        #1;
        check("rst_pcw_hi", pc_write, 1'b1);
        check("rst_state_hold", state, 4'd0);

        // lw, zero-wait memory: 0,1,2,3,4,0
        rst = 1'b0;
        opcode = 7'b0000011;
        #1;
        check("lw_s0", state, 4'd0);
        check("lw_s0_irw", ir_write, 1'b1);
        check("lw_s0_regw", reg_write, 1'b0);
        tick();
        check("lw_s1", state, 4'd1);
        check("lw_s1_srcb", alu_src_b, 2'b10);
        check("lw_s1_imm", imm_sel, 2'b10);
        check("lw_s1_regw", reg_write, 1'b0);
        tick();
        check("lw_s2", state, 4'd2);
        check("lw_s2_imm", imm_sel, 2'b00);
        check("lw_s2_srca", alu_src_a, 1'b1);
        check("lw_s2_regw", reg_write, 1'b0);
        tick();
        check("lw_s3", state, 4'd3);
        check("lw_s3_req", mem_bus.mem_req, 1'b1);
        check("lw_s3_we", mem_bus.mem_we, 1'b0);
        check("lw_s3_regw", reg_write, 1'b0);
        tick();
        check("lw_s4", state, 4'd4);
        check("lw_s4_regw", reg_write, 1'b1);
        check("lw_s4_m2r", mem_to_reg, 1'b1);
        tick();
        check("lw_back", state, 4'd0);
        check("lw_back_regw", reg_write, 1'b0);

        // sw with three stalled cycles in MEM_WR
        opcode = 7'b0100011;
        tick();
        check("sw_s1", state, 4'd1);
        tick();
        check("sw_s2", state, 4'd2);
        check("sw_s2_imm", imm_sel, 2'b01);
        mem_bus.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("sw_wait_state", state, 4'd5);
            check("sw_wait_req_we", {mem_bus.mem_req, mem_bus.mem_we}, 2'b11);
            check("sw_wait_regw", reg_write, 1'b0);
            if (i < 2) tick();
            else begin
                @(posedge clk);
                #1;
            end
        end
        mem_bus.mem_ready = 1'b1;
        #1;
        check("sw_last_state", state, 4'd5);
        check("sw_last_req_we", {mem_bus.mem_req, mem_bus.mem_we}, 2'b11);
        tick();
        check("sw_done", state, 4'd0);
        check("sw_done_we", mem_bus.mem_we, 1'b0);

        // beq taken, then not taken
        opcode = 7'b1100011;
        zero = 1'b1;
        tick();
        tick();
        check("beq1_state", state, 4'd8);
        check("beq1_pcw", pc_write, 1'b1);
        check("beq1_pcsrc", pc_src, 1'b1);
        check("beq1_aluop", alu_op, 2'b01);
        check("beq1_srcb", alu_src_b, 2'b00);
        tick();
        check("beq1_back", state, 4'd0);
        zero = 1'b0;
        tick();
        check("beq0_pcw_decode", pc_write, 1'b0);
        tick();
        check("beq0_state", state, 4'd8);
        check("beq0_pcw", pc_write, 1'b0);
        check("beq0_pcsrc", pc_src, 1'b1);
        check("beq0_aluop", alu_op, 2'b01);
        tick();
        check("beq0_back", state, 4'd0);

        // R-type then I-type ALU flows
        opcode = 7'b0110011;
        tick();
        tick();
        check("r_exec", state, 4'd6);
        check("r_exec_srcb_op", {alu_src_b, alu_op}, 4'b0010);
        tick();
        check("r_wb", state, 4'd7);
        check("r_wb_ctl", {reg_write, mem_to_reg}, 2'b10);
        tick();
        check("r_back", state, 4'd0);
        opcode = 7'b0010011;
        tick();
        tick();
        check("i_exec", state, 4'd6);
        check("i_exec_srcb_imm", {alu_src_b, imm_sel}, 4'b1000);
        tick();
        tick();
        check("i_back", state, 4'd0);

        // Illegal opcode: sticky FAULT until reset
        opcode = 7'b1111111;
        tick();
        tick();
        check("bad_state", state, 4'd9);
        check("bad_fault", fault, 1'b1);
        check("bad_req", mem_bus.mem_req, 1'b0);
        for (int i = 0; i < 20; i++) begin
            mem_bus.mem_ready = i[0];
            zero = i[1];
            tick();
            check("bad_sticky", {state, fault}, {4'd9, 1'b1});
        end
        check("bad_outputs_zero", {pc_write, ir_write, reg_write, pc_src, alu_src_b}, 6'd0);
        rst = 1'b1;
        tick();
        check("bad_rst_state", state, 4'd0);
        check("bad_rst_fault", fault, 1'b0);

        // FETCH timeout: 15 stalled cycles lead to FAULT
        rst = 1'b0;
        mem_bus.mem_ready = 1'b0;
        opcode = 7'b0000011;
        for (int i = 1; i < 15; i++) begin
            check("to_count", dut.u_timer.count, i - 1);
            tick();
            check("to_wait", state, 4'd0);
        end
        tick();
        check("to_fault_state", state, 4'd9);
        check("to_fault", fault, 1'b1);

        // Ready on the 15th cycle completes normally
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        check("edge_count", dut.u_timer.count, 14);
        mem_bus.mem_ready = 1'b1;
        #1;
        check("edge_irw", ir_write, 1'b1);
        tick();
        check("edge_state", state, 4'd1);
        check("edge_fault", fault, 1'b0);

        // Reset mid-wait in MEM_RD
        mem_bus.mem_ready = 1'b0;
        tick();
        check("rd_addr", state, 4'd2);
        tick();
        tick();
        tick();
        check("rd_wait_state", state, 4'd3);
        check("rd_wait_count", dut.u_timer.count, 2);
        rst = 1'b1;
        #1;
        check("rd_rst_comb_req", {mem_bus.mem_req, ir_write}, 2'b10);
        tick();
        check("rd_rst_state", state, 4'd0);
        check("rd_rst_count", dut.u_timer.count, 0);
        check("rd_rst_fault", fault, 1'b0);
        rst = 1'b0;
        tick();
        check("rd_after_count", dut.u_timer.count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
